qar_mem_responder: RTL and testbench



---
 rtl/qar_mem_pkg.sv | 17 +
 rtl/qar_mem_be_merge.sv | 22 ++
 rtl/qar_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_qar_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qar_mem_pkg.sv
// Shared definitions for the QAR data-memory responder: FSM encodings,
// default geometry, wait-counter width and response status codes.
package qar_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int   DEFAULT_DEPTH      = 256;
  localparam int   DEFAULT_ADDR_WIDTH = 8;
  localparam int   WAIT_CNT_W         = 4;
  localparam logic RSP_OK             = 1'b0;
  localparam logic RSP_ERR            = 1'b1;

endpackage

// File: rtl/qar_mem_be_merge.sv
// Byte-enable merge of an old word and a new word into the word to be written;
// shared with future memory-mapped peripherals.
module qar_be_merge (
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  // Select each byte lane from the new word when its enable is set.
  always_comb begin
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        merged_o[8*i +: 8] = new_word_i[8*i +: 8];
      end else begin
        merged_o[8*i +: 8] = old_word_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/qar_mem_responder.sv
// Word-addressed SRAM target for the QAR data bus with programmable wait states.
// Optional feature macro: QAR_MEM_BOUNDS_EN (out-of-range accesses answer with rsp_err).
module qar_mem_responder
  import qar_mem_pkg::*;
#(
  parameter int    DEPTH       = DEFAULT_DEPTH,
  parameter int    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = "data.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_e                  state_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    oob_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    oob_in_s;
  logic                    acc_we_s;
  logic [ADDR_WIDTH-1:0]   acc_idx_s;
  logic [31:0]             acc_wdata_s;
  logic [3:0]              acc_be_s;
  logic                    acc_oob_s;
  logic                    access_s;
  logic                    mem_we_s;
  logic [31:0]             old_word_s;
  logic [31:0]             rd_word_s;
  logic [31:0]             wr_word_d;
  logic                    unused_addr_s;

`ifdef QAR_MEM_BOUNDS_EN
  assign oob_in_s = (req_addr >= 32'(DEPTH * 4));
`else
  assign oob_in_s = 1'b0;
`endif

  assign unused_addr_s = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  // With zero wait states the access uses the live request, otherwise the latched one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we_s    = req_we;
      acc_idx_s   = req_addr[ADDR_WIDTH+1:2];
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
      acc_oob_s   = oob_in_s;
    end else begin
      acc_we_s    = we_q;
      acc_idx_s   = idx_q;
      acc_wdata_s = wdata_q;
      acc_be_s    = be_q;
      acc_oob_s   = oob_q;
    end
  end

  assign access_s   = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));
  assign old_word_s = mem_q[acc_idx_s];
  assign rd_word_s  = (acc_we_s || acc_oob_s) ? 32'h0000_0000 : old_word_s;
  assign mem_we_s   = access_s && acc_we_s && !acc_oob_s && rst_n;

  qar_be_merge u_be_merge (
    .old_word_i (old_word_s),
    .new_word_i (acc_wdata_s),
    .be_i       (acc_be_s),
    .merged_o   (wr_word_d)
  );

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[acc_idx_s] <= wr_word_d;
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= RSP_OK;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'h0;
      oob_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            idx_q       <= req_addr[ADDR_WIDTH+1:2];
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            oob_q       <= oob_in_s;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_word_s;
              rsp_err_q   <= acc_oob_s ? RSP_ERR : RSP_OK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_word_s;
            rsp_err_q   <= acc_oob_s ? RSP_ERR : RSP_OK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_qar_mem_responder.sv
// Scoreboard bench for qar_mem_responder: one instance with 0 and one with 3 wait states.
module tb_qar_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [32:0] exp0_q [$];
  logic [32:0] exp1_q [$];
  logic [31:0] m0 [256];
  logic [31:0] m1 [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  qar_mem_responder #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  qar_mem_responder #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_CYCLES(3), .INIT_FILE("")) u_w3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s %s", name, detail);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    #1;
    if (rst_n && rsp_valid[0] && rsp_ready[0]) begin
      if (exp0_q.size() == 0) fail("rsp0_unexpected", "actual=response required=none");
      else chk("rsp0", {rsp_err[0], rsp_rdata[0]}, exp0_q.pop_front());
    end
    if (rst_n && rsp_valid[1] && rsp_ready[1]) begin
      if (exp1_q.size() == 0) fail("rsp1_unexpected", "actual=response required=none");
      else chk("rsp1", {rsp_err[1], rsp_rdata[1]}, exp1_q.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic exp_rsp, input logic [32:0] exp_v,
                      output int acc_cyc);
    int n = 0;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_be[k]    = be;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      fail("req_accept_timeout", "actual=no_ready required=ready");
      req_valid[k] = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    if (exp_rsp) begin
      if (k == 0) exp0_q.push_back(exp_v);
      else        exp1_q.push_back(exp_v);
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic st(input int k, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] be, input logic [32:0] exp_v);
    int a;
    send(k, 1'b1, addr, wd, be, 1'b1, exp_v, a);
  endtask

  task automatic ld(input int k, input logic [31:0] addr, input logic [32:0] exp_v);
    int a;
    send(k, 1'b0, addr, 32'h0, 4'h0, 1'b1, exp_v, a);
  endtask

  task automatic wait_rsp(input int k, output int n);
    n = 0;
    while (!rsp_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[k]) fail("rsp_timeout", "actual=no_rsp_valid required=rsp_valid");
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (((k == 0) ? exp0_q.size() : exp1_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("drain_timeout", "actual=pending required=empty");
  endtask

  task automatic rand_run(input int k, input int count);
    int          prev = -1;
    int          a;
    int          idx;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] e;
    for (int j = 0; j < count; j++) begin
      we   = 1'($urandom_range(0, 1));
      idx  = 32 + int'($urandom_range(0, 15));
      addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      if (we) begin
        e = 33'h0;
        if (k == 0) m0[idx] = (m0[idx] & ~lane_mask(be)) | (wd & lane_mask(be));
        else        m1[idx] = (m1[idx] & ~lane_mask(be)) | (wd & lane_mask(be));
      end else begin
        e = {1'b0, (k == 0) ? m0[idx] : m1[idx]};
      end
      send(k, we, addr, wd, be, 1'b1, e, a);
      if (prev >= 0) chk("t6_spacing", 33'(a - prev), 33'((k == 0) ? 2 : 5));
      prev = a;
    end
  endtask

  initial begin
    int a;
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_be[k] = 4'h0; rsp_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 33'(req_ready[k]), 33'h1);
      chk("rst_rsp_valid", 33'(rsp_valid[k]), 33'h0);
      chk("rst_rsp_rdata", 33'(rsp_rdata[k]), 33'h0);
      chk("rst_rsp_err",   33'(rsp_err[k]),   33'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Zero wait states: store then load, response one cycle after acceptance.
    send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 33'h0, a);
    wait_rsp(0, n);
    chk("t1_store_latency", 33'(n), 33'h0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEAD_BEEF}, a);
    wait_rsp(0, n);
    chk("t1_load_latency", 33'(n), 33'h0);

    // Byte enables, empty byte enable, ignored low address bits.
    st(0, 32'h0, 32'h1122_3344, 4'hF, 33'h0);
    st(0, 32'h0, 32'hAABB_CCDD, 4'b0101, 33'h0);
    ld(0, 32'h0, {1'b0, 32'h11BB_33DD});
    st(0, 32'h0, 32'hFFFF_FFFF, 4'b0000, 33'h0);
    ld(0, 32'h0, {1'b0, 32'h11BB_33DD});
    ld(0, 32'h3, {1'b0, 32'h11BB_33DD});

    // Addresses beyond the array.
`ifdef QAR_MEM_BOUNDS_EN
    ld(0, 32'h400, {1'b1, 32'h0});
    ld(0, 32'h8000_0010, {1'b1, 32'h0});
    st(0, 32'h400, 32'h1234_5678, 4'hF, {1'b1, 32'h0});
    ld(0, 32'h0, {1'b0, 32'h11BB_33DD});
`else
    ld(0, 32'h400, {1'b0, 32'h11BB_33DD});
    ld(0, 32'h8000_0010, {1'b0, 32'hDEAD_BEEF});
    st(0, 32'h400, 32'h1234_5678, 4'hF, 33'h0);
    ld(0, 32'h0, {1'b0, 32'h1234_5678});
`endif
    drain(0);

    // Three wait states with a stalled response channel.
    st(1, 32'h20, 32'hCAFE_F00D, 4'hF, 33'h0);
    drain(1);
    rsp_ready[1] = 1'b0;
    send(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, {1'b0, 32'hCAFE_F00D}, a);
    wait_rsp(1, n);
    chk("t3_latency", 33'(n), 33'h3);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 33'(rsp_valid[1]), 33'h1);
      chk("t3_hold_rdata", 33'(rsp_rdata[1]), {1'b0, 32'hCAFE_F00D});
      chk("t3_hold_ready", 33'(req_ready[1]), 33'h0);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    chk("t3_pulse_ready", 33'(req_ready[1]), 33'h0);
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    chk("t3_after_ready", 33'(req_ready[1]), 33'h1);
    chk("t3_after_valid", 33'(rsp_valid[1]), 33'h0);
    chk("t3_after_rdata", 33'(rsp_rdata[1]), {1'b0, 32'hCAFE_F00D});
    rsp_ready[1] = 1'b1;
    drain(1);

    // Reset while a store waits: store must be dropped.
    st(1, 32'h8, 32'hA5A5_A5A5, 4'hF, 33'h0);
    drain(1);
    send(1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 1'b0, 33'h0, a);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_req_ready", 33'(req_ready[1]), 33'h1);
    chk("t5_rsp_valid", 33'(rsp_valid[1]), 33'h0);
    chk("t5_rsp_rdata", 33'(rsp_rdata[1]), 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ld(1, 32'h8, {1'b0, 32'hA5A5_A5A5});
    drain(1);

    // Back-to-back random traffic against a reference model.
    for (int i = 32; i < 48; i++) begin
      m0[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      m1[i] = 32'h2000_0000 + 32'(i) * 32'h0011_0011;
      st(0, 32'(i) << 2, m0[i], 4'hF, 33'h0);
      st(1, 32'(i) << 2, m1[i], 4'hF, 33'h0);
    end
    fork
      rand_run(0, 60);
      rand_run(1, 100);
    join
    drain(0);
    drain(1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
